// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and helpers
// for the multicycle ALU and its iterative datapath.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// One iteration per step; exposes the post-step lo/hi values.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt
);

    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // mode 0: {hi,lo} shifts right with the partial sum; mode 1: remainder in hi, quotient fills lo
    always_comb begin
        lo_d   = lo_q;
        hi_d   = hi_q;
        b_d    = b_q;
        mode_d = mode_q;
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, b_q};
        diff   = rem_sh[WIDTH-1:0] - b_q;
        if (load) begin
            lo_d   = a;
            hi_d   = '0;
            b_d    = b;
            mode_d = mode;
        end else if (step) begin
            if (!mode_q) begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end else if (ge) begin
                hi_d = diff;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign lo_nxt = lo_d;
    assign hi_nxt = hi_d;

    // datapath registers; cleared by load, so no reset needed
    always_ff @(posedge clk) begin
        lo_q   <= lo_d;
        hi_q   <= hi_d;
        b_q    <= b_d;
        mode_q <= mode_d;
    end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with start/busy/done handshake; single-cycle ops
// finish on the accepting edge, MULU/DIVU iterate WIDTH steps.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] c_hi_q, c_hi_d;

    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             md_load;
    logic             md_step;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    assign shamt = B[SHW-1:0];

    // single-cycle result from the live operands
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            OP_ADD: alu_res = A + B;
            OP_SUB: alu_res = A - B;
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_SRL: alu_res = A >> shamt;
            OP_SRA: alu_res = $unsigned($signed(A) >>> shamt);
            OP_SLL: alu_res = A << shamt;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            default: alu_res = '0;
        endcase
    end

    // next state, iteration counter and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        c_hi_d  = c_hi_q;
        md_load = 1'b0;
        md_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_multicycle(ALUOp)) begin
                        md_load = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        c_d     = alu_res;
                        c_hi_d  = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                md_step = 1'b1;
                cnt_d   = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    c_d     = md_lo;
                    c_hi_d  = md_hi;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state and output registers; reset aborts any operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
            c_hi_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            c_hi_q  <= c_hi_d;
        end
    end

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .load   (md_load),
        .step   (md_step),
        .mode   (ALUOp == OP_DIVU),
        .a      (A),
        .b      (B),
        .lo_nxt (md_lo),
        .hi_nxt (md_hi)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign C    = c_q;
    assign C_hi = c_hi_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: stimulus pushes expected
// {C_hi,C}; a monitor pops and compares on every done pulse.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A, B;
    logic [3:0]  ALUOp;
    logic        busy, done;
    logic [31:0] C, C_hi;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    multicycle_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .ALUOp (ALUOp),
        .busy  (busy),
        .done  (done),
        .C     (C),
        .C_hi  (C_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got C_hi/C %h_%h expected none",
                         C_hi, C);
            end else begin
                check("result", {C_hi, C}, exp_q.pop_front());
            end
        end
    end

    // issue one op, check latency and busy, return once back in IDLE
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ec, input logic [31:0] eh,
                          input int lat, input bit poke);
        int n;
        @(negedge clk);
        A = a;
        B = b;
        ALUOp = op;
        start = 1'b1;
        exp_q.push_back({eh, ec});
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        ALUOp = 4'd0;
        n = 1;
        while (!done && n < 100) begin
            if (poke && n < 20) begin
                start = n[0];
                ALUOp = 4'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_busy_in_done"}, {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        check({name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int dn;
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        ALUOp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, done, C_hi, C}, 66'd0);
        reset = 1'b0;

        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 1, 0);
        run_op("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 1, 0);
        run_op("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'd0, 1, 0);
        run_op("or", 4'd3, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 32'd0, 1, 0);
        run_op("sra", 4'd5, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 32'd0, 1, 0);
        run_op("srl", 4'd4, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 32'd0, 1, 0);
        run_op("sll", 4'd6, 32'd1, 32'h0000_003F, 32'h8000_0000, 32'd0, 1, 0);
        run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1, 0);
        run_op("slt_false", 4'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 0);
        run_op("mulu_max", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0000_0001, 32'hFFFF_FFFE, 33, 1);
        run_op("mulu_small", 4'd8, 32'd1000, 32'd3000,
               32'd3000000, 32'd0, 33, 0);
        run_op("divu", 4'd9, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
        run_op("divu_zero", 4'd9, 32'h1234, 32'd0,
               32'hFFFF_FFFF, 32'h1234, 33, 0);

        // abort a DIVU mid-flight with reset
        @(negedge clk);
        A = 32'd5000;
        B = 32'd3;
        ALUOp = 4'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("abort_state", {busy, done, C_hi, C}, 66'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        run_op("add_after_abort", 4'd0, 32'd3, 32'd4, 32'd7, 32'd0, 1, 0);
        run_op("op12", 4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0, 1, 0);

        // start held high: accepted every second cycle
        @(negedge clk);
        A = 32'd1;
        B = 32'd1;
        ALUOp = 4'd0;
        start = 1'b1;
        repeat (5) exp_q.push_back({32'd0, 32'd2});
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done == (i % 2 == 0)) dn++;
        end
        start = 1'b0;
        check("b2b_pattern", 64'(dn), 64'd10);

        repeat (4) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered ALU for the CPU datapath.
- Widens the operand set and adds shift-left, signed set-less-than, and iterative unsigned multiply/divide.
- Operation is controlled by a start/busy/done handshake.
- Single-cycle ops complete in 1 cycle. MULU/DIVU run a WIDTH-cycle shift-add / restoring-divide loop and return a double result (C, C_hi).

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from B (derived; not overridden).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  operand A; captured on accepted start.
- B  in  WIDTH  operand B; captured on accepted start.
- ALUOp  in  4  operation select; captured on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; C/C_hi valid from this cycle.
- C  out  WIDTH  result: low product or quotient.
- C_hi  out  WIDTH  high product or remainder; 0 for single-cycle ops.

Behaviour:
- Reset: one clk edge with reset=1 forces state=IDLE, C=0, C_hi=0, done=0, busy=0. This applies from any state and aborts an in-flight MULU/DIVU with no result and no done.
- Op encoding:
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 SRL A>>B[SHW-1:0]
  - 5 SRA signed A>>>B[SHW-1:0]
  - 6 SLL A<<B[SHW-1:0]
  - 7 SLT: 1 if signed A < signed B, else 0
  - 8 MULU, multi-cycle
  - 9 DIVU, multi-cycle
  - 10..15: C=0, single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no overflow flag. Only the low SHW bits of B are used as shift amount. SLT result is zero-extended.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, single-cycle op: on that edge, C = f(A,B), C_hi = 0, go to DONE. Latency is 1 edge.
- IDLE, start=1, op 8/9: on that edge, latch operands, clear accumulator/remainder, cnt=0, go to RUN.
- RUN: one iteration per edge, cnt++.
  - MULU: 2*WIDTH-bit shift-add.
  - DIVU: restoring divide, quotient bit per cycle.
  - When cnt==WIDTH-1, that edge writes C/C_hi and goes to DONE.
  - Latency from accepting edge to done is WIDTH+1 edges.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued. Max single-op throughput is 1 per 2 cycles.
- Operand changes after acceptance have no effect on the result.
- C/C_hi hold their last value until the next completion writes them. They are not cleared in IDLE.
- Divide by zero (B=0): C = all ones, C_hi = A. This is the natural restoring result and needs no special state.
- MULU full product: C = low WIDTH bits, C_hi = high WIDTH bits.
- reset and start in the same cycle: reset wins and start is dropped.

Decomposition:
- Package alu_pkg holds:
  - localparam op codes OP_ADD..OP_DIVU (4-bit)
  - FSM state encoding (IDLE/RUN/DONE, 2-bit)
  - a function is_multicycle(op)
- Sub-module iter_muldiv: iterative multiply/divide datapath.
  - Inputs: clk, load, step, mode, operands.
  - Outputs: lo/hi registers.
  - Contains its own WIDTH-bit shifts and adder/subtractor; the top-level FSM drives load/step and owns cnt.
- The top level owns the FSM, the single-cycle combinational ops and the output registers.

Test Plan:
- Reset, then start ADD A=0xFFFFFFFF B=2 -> done pulses one edge later, C=0x00000001, C_hi=0, busy high exactly 1 cycle (DONE).
- SRA A=0x80000000 B=0x00000024 (shamt 4) -> C=0xF8000000. SRL same inputs -> C=0x08000000. SLT A=0xFFFFFFFF B=1 -> C=1.
- MULU A=0xFFFFFFFF B=0xFFFFFFFF -> done at edge 33 after accept, C=0x00000001, C_hi=0xFFFFFFFE. start pulses during RUN are ignored and the result is unchanged.
- DIVU A=100 B=7 -> C=14, C_hi=2. DIVU A=0x1234 B=0 -> C=0xFFFFFFFF, C_hi=0x1234.
- Reset asserted at cycle 10 of a DIVU -> next cycle busy=0, done never pulses, C=C_hi=0. A following ADD 3+4 -> C=7.
- ALUOp=12 with any operands -> done after 1 edge, C=0, C_hi=0. Back-to-back start held high -> accepted every 2nd cycle.
